text_console: RTL



---
 rtl/text_console_pkg.sv | 17 +
 rtl/text_console_addr.sv | 10 +
 rtl/text_console.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console front end.
package text_console_pkg;

  typedef enum logic [2:0] {
    SYNX, SYNY, IDLE, PUT, CLR, CURX, CURY
  } state_t;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [31:0] OFF_CRX  = 32'd1;
  localparam logic [31:0] OFF_CRY  = 32'd2;
  localparam logic [31:0] OFF_TEXT = 32'h10;

endpackage

// File: rtl/text_console_addr.sv
// (row, col) -> text RAM cell offset; row*80 built as (row<<6)+(row<<4).
module text_console_addr (
  input  logic [5:0]  row,
  input  logic [6:0]  col,
  output logic [11:0] off
);

  assign off = {row, 6'b0} + {2'b0, row, 4'b0} + {5'b0, col};

endmodule

// File: rtl/text_console.sv
// Character stream to VGA text RAM / cursor MMR writer.
// Bus outputs are registered from the next state so each write lands in its own state's cycle.
module text_console
  import text_console_pkg::*;
#(
  parameter logic [31:0] VIDEO_ADDR = 32'h0001_0000,
  parameter int          COLS       = 80,
  parameter int          ROWS       = 40,
  parameter logic [7:0]  FILL       = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        strobe,
  output logic        rw,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [6:0]  cur_col,
  output logic [5:0]  cur_row
);

  localparam logic [6:0]  COL_MAX     = 7'(COLS - 1);
  localparam logic [5:0]  ROW_MAX     = 6'(ROWS - 1);
  localparam logic [11:0] ROW_LAST    = 12'(COLS - 1);
  localparam logic [11:0] SCREEN_LAST = 12'(COLS * ROWS - 1);

  state_t      state, state_nx;
  logic [6:0]  col_nx;
  logic [5:0]  row_nx;
  logic [11:0] clr_cnt, clr_cnt_nx, clr_end, clr_end_nx;
  logic [11:0] cell_off;
  logic [31:0] addr_nx, data_nx;
  logic        wr_nx, accept, printable;
  logic        issue_crx, issue_cry, start_clr;

  text_console_addr u_addr (
    .row (cur_row),
    .col (cur_col),
    .off (cell_off)
  );

  assign accept    = in_valid & in_ready;
  assign printable = (in_char >= 8'h20) && (in_char != 8'h7F);
  assign rw        = strobe;

  always_comb begin
    state_nx   = state;
    col_nx     = cur_col;
    row_nx     = cur_row;
    clr_cnt_nx = clr_cnt;
    clr_end_nx = clr_end;
    wr_nx      = 1'b0;
    addr_nx    = addr;
    data_nx    = data;
    issue_crx  = 1'b0;
    issue_cry  = 1'b0;
    start_clr  = 1'b0;

    unique case (state)
      // SYNX is the reset-release cycle; the resync writes occupy SYNY and CURY.
      SYNX: begin state_nx = SYNY; issue_crx = 1'b1; end
      SYNY: begin state_nx = CURY; issue_cry = 1'b1; end
      IDLE: begin
        if (accept) begin
          if (printable) begin
            state_nx = PUT;
            wr_nx    = 1'b1;
            addr_nx  = VIDEO_ADDR + OFF_TEXT + 32'(cell_off);
            data_nx  = {24'h0, in_char};
          end else begin
            unique case (in_char)
              CH_CR: begin col_nx = '0; state_nx = CURX; issue_crx = 1'b1; end
              CH_LF: begin
                col_nx = '0;
                if (cur_row == ROW_MAX) begin
                  row_nx = '0; start_clr = 1'b1; clr_end_nx = ROW_LAST;
                end else begin
                  row_nx = cur_row + 6'd1; state_nx = CURX; issue_crx = 1'b1;
                end
              end
              CH_BS: begin
                if (cur_col != '0) col_nx = cur_col - 7'd1;
                else if (cur_row != '0) begin col_nx = COL_MAX; row_nx = cur_row - 6'd1; end
                state_nx  = CURX;
                issue_crx = 1'b1;
              end
              CH_FF: begin
                col_nx = '0; row_nx = '0; start_clr = 1'b1; clr_end_nx = SCREEN_LAST;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        if (cur_col < COL_MAX) begin
          col_nx = cur_col + 7'd1; state_nx = CURX; issue_crx = 1'b1;
        end else begin
          col_nx = '0;
          if (cur_row == ROW_MAX) begin
            row_nx = '0; start_clr = 1'b1; clr_end_nx = ROW_LAST;
          end else begin
            row_nx = cur_row + 6'd1; state_nx = CURX; issue_crx = 1'b1;
          end
        end
      end
      CLR: begin
        if (clr_cnt == clr_end) begin
          state_nx = CURX; issue_crx = 1'b1;
        end else begin
          clr_cnt_nx = clr_cnt + 12'd1;
          wr_nx      = 1'b1;
          addr_nx    = VIDEO_ADDR + OFF_TEXT + 32'(clr_cnt_nx);
          data_nx    = {24'h0, FILL};
        end
      end
      CURX:    begin state_nx = CURY; issue_cry = 1'b1; end
      CURY:    state_nx = IDLE;
      default: state_nx = SYNX;
    endcase

    if (issue_crx) begin
      wr_nx   = 1'b1;
      addr_nx = VIDEO_ADDR + OFF_CRX;
      data_nx = 32'(col_nx) + 32'd1;
    end
    if (issue_cry) begin
      wr_nx   = 1'b1;
      addr_nx = VIDEO_ADDR + OFF_CRY;
      data_nx = 32'(row_nx);
    end
    // Clearing always starts at offset 0; clr_end selects one row or the whole screen.
    if (start_clr) begin
      state_nx   = CLR;
      clr_cnt_nx = '0;
      wr_nx      = 1'b1;
      addr_nx    = VIDEO_ADDR + OFF_TEXT;
      data_nx    = {24'h0, FILL};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SYNX;
      strobe   <= 1'b0;
      addr     <= '0;
      data     <= '0;
      in_ready <= 1'b0;
      cur_col  <= '0;
      cur_row  <= '0;
      clr_cnt  <= '0;
      clr_end  <= '0;
    end else begin
      state    <= state_nx;
      strobe   <= wr_nx;
      addr     <= addr_nx;
      data     <= data_nx;
      // Drop ready for one cycle after every accepted byte, even a discarded one.
      in_ready <= (state_nx == IDLE) && !accept;
      cur_col  <= col_nx;
      cur_row  <= row_nx;
      clr_cnt  <= clr_cnt_nx;
      clr_end  <= clr_end_nx;
    end
  end

endmodule
